// File: rtl/morph_pkg.sv
// Shared types for the morphology stream: operating modes, stage operator
// selection, per-pixel marker bundle and the pixel word width derivation.
package morph_pkg;

  typedef enum logic [2:0] {
    MODE_BYPASS = 3'b000,
    MODE_ERODE  = 3'b001,
    MODE_DILATE = 3'b010,
    MODE_OPEN   = 3'b011,
    MODE_CLOSE  = 3'b100
  } mode_e;

  typedef enum logic {
    OP_MIN = 1'b0,
    OP_MAX = 1'b1
  } op_e;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } tap_t;

  function automatic int pix_width(input int dw, input int ch);
    return dw * ch;
  endfunction

  // Unused encodings fall back to bypass.
  function automatic mode_e decode_mode(input logic [2:0] raw);
    case (raw)
      3'b001:  return MODE_ERODE;
      3'b010:  return MODE_DILATE;
      3'b011:  return MODE_OPEN;
      3'b100:  return MODE_CLOSE;
      default: return MODE_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/morph_stage.sv
// One 3x3 min/max stage: two line buffers, a 3x3 window and raster counters.
// Emits only fully-populated windows, so the output is (W-2) x (H-2).
module morph_stage
  import morph_pkg::*;
#(
  parameter int  DW = 8,
  parameter int  CH = 3,
  parameter int  W  = 250,
  parameter int  H  = 250,
  parameter op_e OP = OP_MIN,
  localparam int PW = pix_width(DW, CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap_op,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [PW-1:0] in_data,
  output tap_t          tap,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [PW-1:0] out_data
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic [CW-1:0] col_q, x;
  logic [RW-1:0] row_q, y;
  logic          active_q;
  logic          accept, last_col, last_row, emit, use_max;

  logic [PW-1:0] lb0 [W];
  logic [PW-1:0] lb1 [W];
  logic [2:0][PW-1:0] cur, c1_q, c2_q;
  logic [8:0][PW-1:0] win;
  logic [PW-1:0]      res;

  // A sof always restarts at (0,0); once a frame completes, pixels are
  // dropped until the next sof.
  assign accept   = in_valid && (in_sof || active_q);
  assign x        = in_sof ? '0 : col_q;
  assign y        = in_sof ? '0 : row_q;
  assign last_col = (x == CW'(W - 1));
  assign last_row = (y == RW'(H - 1));
  assign emit     = accept && (x >= CW'(2)) && (y >= RW'(2));
  assign use_max  = (OP == OP_MAX) ^ swap_op;

  assign tap.valid = accept;
  assign tap.sof   = accept && (x == '0) && (y == '0);
  assign tap.eol   = accept && last_col;
  assign tap.eof   = accept && last_col && last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
    end else if (accept) begin
      col_q    <= last_col ? '0 : x + 1'b1;
      row_q    <= last_col ? (last_row ? '0 : y + 1'b1) : y;
      active_q <= !(last_col && last_row);
    end
  end

  // Newest column: bottom = incoming pixel, then one and two rows above.
  assign cur = {lb1[x], lb0[x], in_data};

  // NOTE: line buffers and window columns carry no reset; rows 0 and 1 of
  // every frame rewrite them before any window that reads them is emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[x] <= in_data;
      lb1[x] <= lb0[x];
      c1_q   <= cur;
      c2_q   <= c1_q;
    end
  end

  assign win = {cur, c1_q, c2_q};

  // NOTE: best/cand are blocking temporaries, assigned before use on every
  // pass, so no latch is inferred.
  always_comb begin
    res = '0;
    for (int c = 0; c < CH; c++) begin
      logic [DW-1:0] best, cand;
      best = win[0][c*DW +: DW];
      cand = '0;
      for (int k = 1; k < 9; k++) begin
        cand = win[k][c*DW +: DW];
        if (use_max ? (cand > best) : (cand < best)) best = cand;
      end
      res[c*DW +: DW] = best;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && (x == CW'(2)) && (y == RW'(2));
      out_eol   <= emit && last_col;
      out_eof   <= emit && last_col && last_row;
      if (emit) out_data <= res;
    end
  end

endmodule

// File: rtl/morph_stream.sv
// Streaming 3x3 greyscale/colour morphology: bypass, erode, dilate, open, close.
// Stage 1 always sees the raw stream; stage 2 consumes stage 1 output.
module morph_stream
  import morph_pkg::*;
#(
  parameter int  DW    = 8,
  parameter int  CH    = 3,
  parameter int  IMG_W = 250,
  parameter int  IMG_H = 250,
  localparam int PW    = pix_width(DW, CH)
) (
  input  logic          lcd_pclk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [PW-1:0] in_data,
  input  logic [2:0]    mode,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic [PW-1:0] out_data
);

  mode_e         mode_q;
  tap_t          s1_tap, s2_tap, byp_q;
  logic [PW-1:0] byp_data, s1_data, s2_data;
  logic          s1_valid, s1_sof, s1_eol, s1_eof;
  logic          s2_valid, s2_sof, s2_eol, s2_eof;
  logic          unused_s2_tap;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_BYPASS;
      byp_q    <= '0;
      byp_data <= '0;
    end else begin
      if (in_valid && in_sof) mode_q <= decode_mode(mode);
      byp_q <= s1_tap;
      if (s1_tap.valid) byp_data <= in_data;
    end
  end

  // Stage 1 defaults to min (erode/open) and swaps to max for dilate/close;
  // stage 2 defaults to max (open) and swaps to min for close.
  morph_stage #(.DW(DW), .CH(CH), .W(IMG_W), .H(IMG_H), .OP(OP_MIN)) u_stage1 (
    .clk       (lcd_pclk),
    .rst_n     (rst_n),
    .swap_op   (mode_q == MODE_DILATE || mode_q == MODE_CLOSE),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .tap       (s1_tap),
    .out_valid (s1_valid),
    .out_sof   (s1_sof),
    .out_eol   (s1_eol),
    .out_eof   (s1_eof),
    .out_data  (s1_data)
  );

  morph_stage #(.DW(DW), .CH(CH), .W(IMG_W-2), .H(IMG_H-2), .OP(OP_MAX)) u_stage2 (
    .clk       (lcd_pclk),
    .rst_n     (rst_n),
    .swap_op   (mode_q == MODE_CLOSE),
    .in_valid  (s1_valid),
    .in_sof    (s1_sof),
    .in_data   (s1_data),
    .tap       (s2_tap),
    .out_valid (s2_valid),
    .out_sof   (s2_sof),
    .out_eol   (s2_eol),
    .out_eof   (s2_eof),
    .out_data  (s2_data)
  );

  assign unused_s2_tap = ^s2_tap;

  always_comb begin
    out_valid = byp_q.valid;
    out_sof   = byp_q.sof;
    out_eol   = byp_q.eol;
    out_eof   = byp_q.eof;
    out_data  = byp_data;
    case (mode_q)
      MODE_ERODE, MODE_DILATE: begin
        out_valid = s1_valid;
        out_sof   = s1_sof;
        out_eol   = s1_eol;
        out_eof   = s1_eof;
        out_data  = s1_data;
      end
      MODE_OPEN, MODE_CLOSE: begin
        out_valid = s2_valid;
        out_sof   = s2_sof;
        out_eol   = s2_eol;
        out_eof   = s2_eof;
        out_data  = s2_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_morph_stream.sv
// Directed bench for morph_stream on an 8x8 single-channel frame.
module tb_morph_stream;

  localparam int DW    = 8;
  localparam int CH    = 1;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int PW    = DW * CH;

  logic          lcd_pclk = 1'b0;
  logic          rst_n    = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof   = 1'b0;
  logic [PW-1:0] in_data  = '0;
  logic [2:0]    mode     = 3'b000;
  logic          out_valid, out_sof, out_eol, out_eof;
  logic [PW-1:0] out_data;

  morph_stream #(.DW(DW), .CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .lcd_pclk  (lcd_pclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .out_data  (out_data)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stray  = 0;
  int drv_cyc;
  int img [64];
  int q_data [$];
  int q_mark [$];
  int q_cyc  [$];

  always @(posedge lcd_pclk) cyc <= cyc + 1;

  always @(negedge lcd_pclk) begin
    if (out_valid) begin
      q_data.push_back(int'(out_data));
      q_mark.push_back({29'd0, out_sof, out_eol, out_eof});
      q_cyc.push_back(cyc);
    end else if (out_sof || out_eol || out_eof) begin
      stray++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_mark.delete();
    q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge lcd_pclk);
  endtask

  // 0 ramp, 1 dark dot at (3,3), 2 bright dot at (4,4), 3 block 2..4 + dot (6,6)
  task automatic fill(input int kind);
    for (int i = 0; i < 64; i++) begin
      int x, y;
      x = i % 8;
      y = i / 8;
      case (kind)
        0:       img[i] = i;
        1:       img[i] = (x == 3 && y == 3) ? 10 : 200;
        2:       img[i] = (x == 4 && y == 4) ? 255 : 0;
        default: img[i] = ((x >= 2 && x <= 4 && y >= 2 && y <= 4) ||
                           (x == 6 && y == 6)) ? 255 : 0;
      endcase
    end
  endtask

  function automatic int exp_px(input int kind, input int x, input int y);
    case (kind)
      0:       return y * 8 + x;
      1:       return (x >= 1 && x <= 3 && y >= 1 && y <= 3) ? 10 : 200;
      2:       return (x >= 2 && x <= 4 && y >= 2 && y <= 4) ? 255 : 0;
      3:       return (x <= 2 && y <= 2) ? 255 : 0;
      default: return (x == 2 && y == 2) ? 255 : 0;
    endcase
  endfunction

  task automatic send(input int n, input int chg_at, input logic [2:0] chg_mode,
                      input bit hold);
    for (int i = 0; i < n; i++) begin
      @(posedge lcd_pclk);
      #1;
      if (i == chg_at) mode = chg_mode;
      if (i == 0) drv_cyc = cyc;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = img[i][PW-1:0];
    end
    if (!hold) begin
      @(posedge lcd_pclk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic verify(input string tag, input int kind, input int w, input int h);
    int n;
    check({tag, " count"}, q_data.size(), w * h);
    n = (q_data.size() < w * h) ? q_data.size() : w * h;
    for (int i = 0; i < n; i++) begin
      int x, y, mk;
      x  = i % w;
      y  = i / w;
      mk = ((i == 0) ? 4 : 0) + ((x == w - 1) ? 2 : 0) + ((i == w * h - 1) ? 1 : 0);
      check($sformatf("%s px(%0d,%0d)", tag, x, y), q_data[i], exp_px(kind, x, y));
      check($sformatf("%s marks(%0d,%0d)", tag, x, y), q_mark[i], mk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [2:0] m, input int img_kind,
                           input int exp_kind, input int w, input int h,
                           input int chg_at, input logic [2:0] chg_mode);
    fill(img_kind);
    mode = m;
    clear_q();
    send(64, chg_at, chg_mode, 1'b0);
    idle(6);
    verify(tag, exp_kind, w, h);
  endtask

  initial begin
    idle(2);
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset markers", int'({out_sof, out_eol, out_eof}), 0);
    rst_n = 1'b1;

    // No sof yet: pixels must be ignored.
    fill(0);
    for (int i = 0; i < 10; i++) begin
      @(posedge lcd_pclk);
      #1;
      in_valid = 1'b1;
      in_data  = img[i][PW-1:0];
    end
    @(posedge lcd_pclk);
    #1 in_valid = 1'b0;
    idle(3);
    check("no output before sof", q_data.size(), 0);

    run_frame("bypass", 3'b000, 0, 0, 8, 8, -1, 3'b000);
    if (q_cyc.size() > 0) check("bypass latency", q_cyc[0] - drv_cyc, 1);

    // Surplus pixels after a complete frame are dropped.
    clear_q();
    for (int i = 0; i < 5; i++) begin
      @(posedge lcd_pclk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    @(posedge lcd_pclk);
    #1 in_valid = 1'b0;
    idle(3);
    check("post-frame ignored", q_data.size(), 0);

    run_frame("erode",  3'b001, 1, 1, 6, 6, -1, 3'b000);
    run_frame("dilate", 3'b010, 2, 2, 6, 6, -1, 3'b000);
    run_frame("open",   3'b011, 3, 3, 4, 4, -1, 3'b000);
    run_frame("close",  3'b100, 2, 4, 4, 4, -1, 3'b000);
    run_frame("reserved mode", 3'b111, 0, 0, 8, 8, -1, 3'b000);

    run_frame("chg keeps erode", 3'b001, 1, 1, 6, 6, 10, 3'b010);
    run_frame("chg next dilate", 3'b010, 2, 2, 6, 6, -1, 3'b000);

    // Asynchronous reset in the middle of a bypass frame.
    fill(0);
    mode = 3'b000;
    clear_q();
    send(20, -1, 3'b000, 1'b1);
    @(posedge lcd_pclk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("pre-reset out_valid", int'(out_valid), 1);
    check("pre-reset out_data", int'(out_data), 19);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset out_data", int'(out_data), 0);
    check("async reset markers", int'({out_sof, out_eol, out_eof}), 0);
    idle(2);
    #1 rst_n = 1'b1;
    run_frame("after reset", 3'b001, 1, 1, 6, 6, -1, 3'b000);

    // A new sof at pixel 30 abandons the partial frame.
    fill(2);
    mode = 3'b010;
    send(30, -1, 3'b000, 1'b0);
    idle(3);
    run_frame("restart sof", 3'b010, 2, 2, 6, 6, -1, 3'b000);

    check("markers only with valid", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morph_stream.md
MORPH_STREAM -- requirements
Module: morph_stream

Interface
REQ-001 The block SHALL have parameter DW, default 8, bits per colour channel.
REQ-002 The block SHALL have parameter CH, default 3, channels per pixel; pixel word width PW = DW*CH.
REQ-003 The block SHALL have parameter IMG_W, default 250, input frame width in pixels.
REQ-004 The block SHALL have parameter IMG_H, default 250, input frame height in pixels.
REQ-005 The block SHALL have the port lcd_pclk  in  1  as its single clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port rst_n  in  1  as its reset: asynchronous, active-low.
REQ-007 The block SHALL have the ports in_valid  in  1  (input pixel strobe) and in_sof  in  1  (first pixel of a frame, qualified by in_valid).
REQ-008 The block SHALL have the port in_data  in  PW  (raster-order input pixel).
REQ-009 The block SHALL have the port mode  in  3  (000 bypass, 001 erode, 010 dilate, 011 open, 100 close, others bypass).
REQ-010 The block SHALL have the ports out_valid, out_sof, out_eol, out_eof  out  1 each (output strobe and frame/row markers).
REQ-011 The block SHALL have the port out_data  out  PW  (filtered pixel).

Function
REQ-012 The block SHALL have no backpressure; every in_valid pixel is consumed in its cycle.
REQ-013 The block SHALL sample mode only on an in_valid && in_sof cycle and hold it for the whole frame.
REQ-014 Erode SHALL output, per channel independently, the minimum of the 3x3 window; dilate SHALL output the per-channel maximum.
REQ-015 Open SHALL be erode followed by dilate; close SHALL be dilate followed by erode.
REQ-016 Each 3x3 stage SHALL emit only fully-populated windows (no padding), so a stage shrinks the frame by 2 in each axis.
REQ-017 Output size SHALL be: bypass IMG_W x IMG_H; erode and dilate (IMG_W-2) x (IMG_H-2); open and close (IMG_W-4) x (IMG_H-4).
REQ-018 A stage SHALL emit the window centred at (x-1, y-1) one cycle after accepting input (x, y), for x>=2 and y>=2.
REQ-019 Bypass SHALL emit in_data one cycle after acceptance.
REQ-020 The output markers SHALL be asserted only together with out_valid: out_sof on output (0,0), out_eol on the last column of each output row, out_eof on the last output pixel.
REQ-021 Each stage SHALL hold a column counter and a row counter; the column counter wraps at its stage width and increments the row counter.
REQ-022 Pixels arriving after IMG_W*IMG_H accepted pixels and before the next in_sof SHALL be ignored.
REQ-023 An in_sof mid-frame SHALL abandon the current frame: counters restart at (0,0), no further output is produced from the old frame, and line-buffer contents are treated as invalid.
REQ-024 Two line buffers per stage, each of depth equal to its stage width, SHALL be written and read at the same column address in the same cycle (read-before-write).
REQ-025 In two-stage modes, stage 2 SHALL be fed only by the out_valid/out_data of stage 1, with width IMG_W-2.

Reset
REQ-026 On rst_n low, all out_* ports SHALL be 0, all counters 0, and the latched mode 000.
REQ-027 After reset is released, the block SHALL produce no output until the first in_valid && in_sof.
REQ-028 Line-buffer RAM contents SHALL NOT require reset.

Structure
REQ-029 The mode encodings and the PW derivation SHALL live in the shared package morph_pkg.
REQ-030 The sub-module morph_stage (parameters DW, CH, W, H, OP = min/max) SHALL implement the line buffers, the window and the counters, and SHALL be instantiated twice.
REQ-031 The top level SHALL contain only the mode latch, the stage routing/muxing, and the bypass register.

Verification (IMG_W=8, IMG_H=8, DW=8, CH=1)
REQ-032 Bypass: ramp 0..63 -> out_data 0..63, one cycle late, 64 strobes, out_eol x8, out_eof on value 63.
REQ-033 Erode: all pixels 200 except 10 at (3,3) -> 36 outputs; value 10 at output (x,y) with x,y in 1..3, all others 200.
REQ-034 Dilate: 0 background, 255 at (4,4) -> 36 outputs; value 255 at output x,y in 2..4, all others 0.
REQ-035 Open: 255 on a 3x3 block at rows/cols 2..4 plus an isolated 255 at (6,6) -> 16 outputs; 255 at output rows/cols 0..2, all others 0 (isolated pixel removed).
REQ-036 Mode change from erode to dilate at pixel 10 -> current frame completes as erode; the next frame is dilate.
REQ-037 rst_n low after 20 pixels -> out_* go to 0 at once with no out_valid; the next in_sof frame is correct. An in_sof at pixel 30 -> old frame discarded, new frame correct.
